output_port_allocator: RTL and testbench

- Per-output-port scheduler for the NoC router crossbar.
- Shares one output link among NUM_INPUTS input FIFOs with round-robin arbitration.
- Holds the grant for a whole packet (wormhole lock, head to tail).
- Gates each flit on downstream credits, tracked against the neighbour's FLIT_BUFFER_DEPTH-entry input buffer, and produces the send strobe for that port.

---
 rtl/noc_router_pkg.sv | 18 +
 rtl/output_port_allocator_if.sv | 29 ++
 rtl/output_port_allocator_rr_arbiter.sv | 28 ++
 rtl/output_port_allocator.sv | 132 +++++++++++++
 tb/tb_output_port_allocator.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/noc_router_pkg.sv
// Shared NoC router types and constants used by the per-port allocator.
package noc_router_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_e;

   localparam int unsigned NUM_PORTS                 = 5;
   localparam int unsigned DEFAULT_FLIT_BUFFER_DEPTH = 8;

   localparam int unsigned LOCAL = 0;
   localparam int unsigned NORTH = 1;
   localparam int unsigned SOUTH = 2;
   localparam int unsigned EAST  = 3;
   localparam int unsigned WEST  = 4;

endpackage

// File: rtl/output_port_allocator_if.sv
// Request/grant/credit bundle between the input FIFOs and one output-port allocator.
interface output_port_allocator_if #(
   parameter  int unsigned NUM_INPUTS        = 5,
   parameter  int unsigned FLIT_BUFFER_DEPTH = 8,
   localparam int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
   localparam int unsigned OWNER_WIDTH       = $clog2(NUM_INPUTS)
);

   logic [NUM_INPUTS-1:0]   req;
   logic [NUM_INPUTS-1:0]   req_is_tail;
   logic                    credit_in;
   logic [NUM_INPUTS-1:0]   grant;
   logic                    send_out;
   logic                    locked;
   logic [OWNER_WIDTH-1:0]  owner;
   logic [CREDIT_WIDTH-1:0] credit_count;
   logic                    credit_overflow;

   modport master (
      output req, req_is_tail, credit_in,
      input  grant, send_out, locked, owner, credit_count, credit_overflow
   );

   modport slave (
      input  req, req_is_tail, credit_in,
      output grant, send_out, locked, owner, credit_count, credit_overflow
   );

endinterface

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req searching upward from ptr+1.
module rr_arbiter #(
   parameter  int unsigned NUM_INPUTS = 5,
   localparam int unsigned PTR_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [PTR_WIDTH-1:0]  ptr,
   input  logic                  en,
   output logic [NUM_INPUTS-1:0] gnt
);

   logic        found;
   int unsigned idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
         idx = (32'(ptr) + k) % NUM_INPUTS;
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port scheduler: round-robin arbitration, wormhole lock, credit gating.
module output_port_allocator
   import noc_router_pkg::*;
#(
   parameter  int unsigned NUM_INPUTS        = NUM_PORTS,
   parameter  int unsigned FLIT_BUFFER_DEPTH = DEFAULT_FLIT_BUFFER_DEPTH,
   localparam int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
   localparam int unsigned OWNER_WIDTH       = $clog2(NUM_INPUTS)
) (
   input  logic                    clk_noc,
   input  logic                    rst_n,
   output_port_allocator_if.slave  bus
);

   localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [OWNER_WIDTH-1:0]  PTR_RESET   = OWNER_WIDTH'(NUM_INPUTS - 1);

   alloc_state_e            state_q, state_d;
   logic [OWNER_WIDTH-1:0]  owner_q, owner_d;
   logic [OWNER_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic                    overflow_q, overflow_d;

   logic                    credit_ok;
   logic                    arb_en;
   logic [NUM_INPUTS-1:0]   arb_gnt;
   logic [NUM_INPUTS-1:0]   grant_c;
   logic                    send_c;
   logic [OWNER_WIDTH-1:0]  winner;

   assign credit_ok = (credit_q != '0);
   assign arb_en    = (state_q == IDLE) && credit_ok;

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_rr_arbiter (
      .req (bus.req),
      .ptr (rr_ptr_q),
      .en  (arb_en),
      .gnt (arb_gnt)
   );

   // One-hot arbiter grant to winner index.
   always_comb begin
      winner = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (arb_gnt[i]) winner = OWNER_WIDTH'(i);
      end
   end

   // Grant is forced low while reset is held; a locked port only serves its owner.
   always_comb begin
      grant_c = '0;
      if (rst_n && credit_ok) begin
         if (state_q == LOCKED) begin
            if (bus.req[owner_q]) grant_c[owner_q] = 1'b1;
         end else begin
            grant_c = arb_gnt;
         end
      end
   end

   assign send_c = |grant_c;

   // Lock FSM; priority only rotates when a tail flit leaves.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (send_c) begin
               if (bus.req_is_tail[winner]) begin
                  rr_ptr_d = winner;
               end else begin
                  state_d = LOCKED;
                  owner_d = winner;
               end
            end
         end
         LOCKED: begin
            if (send_c && bus.req_is_tail[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = owner_q;
               owner_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
         end
      endcase
   end

   // Credit counter: a send and a returned credit in the same cycle cancel.
   always_comb begin
      credit_d   = credit_q;
      overflow_d = overflow_q;
      case ({send_c, bus.credit_in})
         2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
         2'b01: begin
            if (credit_q == CREDIT_FULL) overflow_d = 1'b1;
            else                         credit_d   = credit_q + CREDIT_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= PTR_RESET;
         credit_q   <= CREDIT_FULL;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.grant           = grant_c;
   assign bus.send_out        = send_c;
   assign bus.locked          = (state_q == LOCKED);
   assign bus.owner           = owner_q;
   assign bus.credit_count    = credit_q;
   assign bus.credit_overflow = overflow_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed-vector bench for output_port_allocator with a queue-based scoreboard.
module tb_output_port_allocator;

   typedef struct {
      int         id;
      logic [4:0] grant;
      logic       locked;
      logic [2:0] owner;
      logic [3:0] credit;
      logic       ovf;
   } exp_t;

   logic clk_noc = 1'b0;
   logic rst_n   = 1'b0;

   int compared   = 0;
   int mismatched = 0;
   int step_id    = 0;
   exp_t exp_q[$];

   output_port_allocator_if #(.NUM_INPUTS(5), .FLIT_BUFFER_DEPTH(8)) bus ();

   output_port_allocator #(
      .NUM_INPUTS        (5),
      .FLIT_BUFFER_DEPTH (8)
   ) dut (
      .clk_noc (clk_noc),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_noc = ~clk_noc;

   task automatic chk(input int id, input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL step %0d %s: got %0d expected %0d", id, name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   task automatic step(input logic rst, input logic [4:0] r, input logic [4:0] t, input logic c,
                       input logic [4:0] eg, input logic el, input logic [2:0] eo,
                       input logic [3:0] ec, input logic ev);
      exp_t e;
      @(posedge clk_noc);
      #1;
      rst_n           = rst;
      bus.req         = r;
      bus.req_is_tail = t;
      bus.credit_in   = c;
      e.id = step_id; e.grant = eg; e.locked = el; e.owner = eo; e.credit = ec; e.ovf = ev;
      exp_q.push_back(e);
      step_id++;
   endtask

   // Monitor: outputs are stable mid-cycle, compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_noc);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.id, "grant",           8'(bus.grant),           8'(e.grant));
            chk(e.id, "send_out",        8'(bus.send_out),        8'(|e.grant));
            chk(e.id, "locked",          8'(bus.locked),          8'(e.locked));
            chk(e.id, "owner",           8'(bus.owner),           8'(e.owner));
            chk(e.id, "credit_count",    8'(bus.credit_count),    8'(e.credit));
            chk(e.id, "credit_overflow", 8'(bus.credit_overflow), 8'(e.ovf));
         end
      end
   end

   initial begin
      bus.req         = '0;
      bus.req_is_tail = '0;
      bus.credit_in   = 1'b0;

      // Reset holds grant low regardless of requests.
      step(0, 5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 8, 0);
      step(0, 5'b11111, 5'b11111, 0, 5'b00000, 0, 0, 8, 0);

      // Single-flit packets from inputs 1 and 2 alternate; credits balanced.
      step(1, 5'b00110, 5'b00110, 1, 5'b00010, 0, 0, 8, 0);
      step(1, 5'b00110, 5'b00110, 1, 5'b00100, 0, 0, 8, 0);
      step(1, 5'b00110, 5'b00110, 1, 5'b00010, 0, 0, 8, 0);
      step(1, 5'b00110, 5'b00110, 1, 5'b00100, 0, 0, 8, 0);

      // 4-flit packet from input 3 holds the port against input 0, with one bubble.
      step(1, 5'b01001, 5'b00001, 0, 5'b01000, 0, 0, 8, 0);
      step(1, 5'b01001, 5'b00001, 0, 5'b01000, 1, 3, 7, 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00000, 1, 3, 6, 0);
      step(1, 5'b01001, 5'b00001, 0, 5'b01000, 1, 3, 6, 0);
      step(1, 5'b01001, 5'b01001, 0, 5'b01000, 1, 3, 5, 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00001, 0, 0, 4, 0);

      // Send and credit return in the same cycle leave the count at 3.
      step(1, 5'b00001, 5'b00001, 1, 5'b00001, 0, 0, 3, 0);
      step(1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 3, 0);

      for (int k = 3; k <= 7; k++) step(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 4'(k), 0);

      // Credit exhaustion: eight grants, stall, one credit buys exactly one flit.
      for (int k = 8; k >= 1; k--) step(1, 5'b00001, 5'b00001, 0, 5'b00001, 0, 0, 4'(k), 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00000, 0, 0, 0, 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00000, 0, 0, 0, 0);
      step(1, 5'b00001, 5'b00001, 1, 5'b00000, 0, 0, 0, 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00001, 0, 0, 1, 0);
      step(1, 5'b00001, 5'b00001, 0, 5'b00000, 0, 0, 0, 0);

      for (int k = 0; k <= 7; k++) step(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 4'(k), 0);

      // Overflow saturates and stays sticky.
      step(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 8, 0);
      step(1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 8, 1);
      step(1, 5'b00001, 5'b00001, 0, 5'b00001, 0, 0, 8, 1);
      step(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 7, 1);

      // Reset mid-packet with input 2 locked and 5 credits.
      step(1, 5'b00100, 5'b00000, 0, 5'b00100, 0, 0, 8, 1);
      step(1, 5'b00100, 5'b00000, 0, 5'b00100, 1, 2, 7, 1);
      step(1, 5'b00100, 5'b00000, 0, 5'b00100, 1, 2, 6, 1);
      step(1, 5'b00000, 5'b00000, 0, 5'b00000, 1, 2, 5, 1);
      step(0, 5'b11111, 5'b00000, 0, 5'b00000, 0, 0, 8, 0);
      step(0, 5'b11111, 5'b11111, 0, 5'b00000, 0, 0, 8, 0);
      step(1, 5'b11111, 5'b11111, 0, 5'b00001, 0, 0, 8, 0);
      step(1, 5'b11111, 5'b11111, 0, 5'b00010, 0, 0, 7, 0);
      step(1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 6, 0);

      repeat (4) @(posedge clk_noc);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
